// File: rtl/conv5x5_mac.sv
// conv5x5_mac: sequential 5x5 convolution multiply-accumulate.
// Accepts one unsigned pixel per cycle and multiplies it by the matching
// signed kernel tap. The 25 products of a window are summed exactly into a
// 21-bit signed result. The kernel is captured on tap 0 so that weight
// writes made mid-window only take effect in the next window.
module conv5x5_mac (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [199:0]        iWeights,
  input  logic                iPixValid,
  input  logic [7:0]          iPix,
  output logic                oPixReady,
  input  logic                iClear,
  output logic                oValid,
  output logic signed [20:0]  oSum,
  input  logic                iReady,
  output logic                oBusy
);

  logic [4:0]         tap_q, tap_d;
  logic [199:0]       shadow_q, shadow_d;
  logic signed [16:0] prod_q, prod_d;
  logic               pvalid_q, pvalid_d;
  logic               pfirst_q, pfirst_d;
  logic               plast_q, plast_d;
  logic signed [20:0] acc_q, acc_d;
  logic signed [20:0] sum_q, sum_d;
  logic               ovalid_q, ovalid_d;
  logic               rdy_en_q;

  logic               stall;
  logic               pix_ready;
  logic               accept;
  logic signed [7:0]  w_sel;
  logic signed [16:0] prod_now;
  logic signed [20:0] prod_ext;
  logic signed [20:0] acc_next;

  // Handshake, tap weight selection and the product/accumulate datapath.
  // Tap 0 reads the live bank because the snapshot is only being taken on
  // that same edge.
  always_comb begin
    stall     = pvalid_q && plast_q && ovalid_q && !iReady;
    pix_ready = rdy_en_q && !stall && !iClear;
    accept    = iPixValid && pix_ready;
    w_sel     = (tap_q == 5'd0) ? iWeights[7:0] : shadow_q[{tap_q, 3'b000} +: 8];
    prod_now  = $signed({{9{w_sel[7]}}, w_sel}) * $signed({9'b0, iPix});
    prod_ext  = {{4{prod_q[16]}}, prod_q};
    acc_next  = pfirst_q ? prod_ext : acc_q + prod_ext;
  end

  // Next-state for the tap counter, kernel snapshot and product stage.
  // A stall has priority over iClear so a held final product is never lost.
  always_comb begin
    tap_d    = tap_q;
    shadow_d = shadow_q;
    prod_d   = prod_q;
    pvalid_d = pvalid_q;
    pfirst_d = pfirst_q;
    plast_d  = plast_q;
    if (iClear) begin
      tap_d = 5'd0;
    end else if (accept) begin
      tap_d = (tap_q == 5'd24) ? 5'd0 : tap_q + 5'd1;
    end
    if (accept && tap_q == 5'd0) begin
      shadow_d = iWeights;
    end
    if (!stall) begin
      if (accept) begin
        prod_d   = prod_now;
        pvalid_d = 1'b1;
        pfirst_d = (tap_q == 5'd0);
        plast_d  = (tap_q == 5'd24);
      end else begin
        pvalid_d = 1'b0;
      end
    end
  end

  // Next-state for the accumulator and the output register. A new result may
  // replace the old one on the same edge it is drained.
  always_comb begin
    acc_d    = acc_q;
    sum_d    = sum_q;
    ovalid_d = ovalid_q && !iReady;
    if (pvalid_q && !stall) begin
      acc_d = acc_next;
      if (plast_q) begin
        sum_d    = acc_next;
        ovalid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      tap_q    <= '0;
      shadow_q <= '0;
      prod_q   <= '0;
      pvalid_q <= 1'b0;
      pfirst_q <= 1'b0;
      plast_q  <= 1'b0;
      acc_q    <= '0;
      sum_q    <= '0;
      ovalid_q <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      tap_q    <= tap_d;
      shadow_q <= shadow_d;
      prod_q   <= prod_d;
      pvalid_q <= pvalid_d;
      pfirst_q <= pfirst_d;
      plast_q  <= plast_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      ovalid_q <= ovalid_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign oPixReady = pix_ready;
  assign oValid    = ovalid_q;
  assign oSum      = sum_q;
  assign oBusy     = (tap_q != 5'd0) || pvalid_q;

endmodule

// File: tb/tb_conv5x5_mac.sv
// Self-checking bench for conv5x5_mac: directed scenarios plus randomized
// windows compared against a plain dot-product reference model.
module tb_conv5x5_mac;

  logic               iCLK;
  logic               iRST;
  logic [199:0]       iWeights;
  logic               iPixValid;
  logic [7:0]         iPix;
  logic               oPixReady;
  logic               iClear;
  logic               oValid;
  logic signed [20:0] oSum;
  logic               iReady;
  logic               oBusy;

  int n_total  = 0;
  int n_passed = 0;
  int cyc      = 0;
  bit rand_ready = 0;
  int got_q[$];
  int got_cyc[$];

  conv5x5_mac dut (
    .iCLK(iCLK), .iRST(iRST), .iWeights(iWeights), .iPixValid(iPixValid),
    .iPix(iPix), .oPixReady(oPixReady), .iClear(iClear), .oValid(oValid),
    .oSum(oSum), .iReady(iReady), .oBusy(oBusy)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cyc <= cyc + 1;

  // Log every result consumed by the handshake.
  always @(posedge iCLK) begin
    if (iRST === 1'b0 && oValid === 1'b1 && iReady === 1'b1) begin
      got_q.push_back(int'(oSum));
      got_cyc.push_back(cyc);
    end
  end

  // Reference: sum over taps of signed weight times unsigned pixel.
  function automatic int model(input logic [199:0] w, input logic [7:0] px[25]);
    int s;
    logic signed [7:0] ws;
    s = 0;
    for (int k = 0; k < 25; k++) begin
      ws = w[8*k +: 8];
      s += int'(ws) * int'({24'd0, px[k]});
    end
    return s;
  endfunction

  function automatic logic [199:0] fill_w(input logic [7:0] v);
    logic [199:0] w;
    for (int k = 0; k < 25; k++) w[8*k +: 8] = v;
    return w;
  endfunction

  task automatic drive_pixel(input logic [7:0] p);
    bit done;
    int n;
    done = 0;
    n = 0;
    while (!done) begin
      @(negedge iCLK);
      iPixValid = 1'b1;
      iPix = p;
      if (rand_ready) iReady = 1'($urandom_range(0, 1));
      #1;
      done = (oPixReady === 1'b1);
      @(posedge iCLK);
      n++;
      if (!done && n > 300) begin
        n_total++;
        $display("FAIL pixel_accept_timeout: oPixReady=%b expected 1", oPixReady);
        done = 1;
      end
    end
  endtask

  task automatic drive_window(input logic [7:0] px[25], input int chg_tap,
                              input logic [199:0] chg_w);
    for (int k = 0; k < 25; k++) begin
      if (k == chg_tap) begin
        #1 iWeights = chg_w;
      end
      drive_pixel(px[k]);
    end
  endtask

  task automatic go_idle();
    @(negedge iCLK);
    iPixValid = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    int c;
    c = 0;
    while (got_q.size() < n && c < 400) begin
      @(posedge iCLK);
      c++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    iRST = 1'b1; iPixValid = 1'b0; iPix = '0; iClear = 1'b0; iReady = 1'b1;
    iWeights = '0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    n_total++; if (oPixReady !== 1'b0) $display("FAIL reset_pixready: got %b expected 0", oPixReady); else n_passed++;
    n_total++; if (oValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", oValid); else n_passed++;
    n_total++; if (oSum !== 21'sd0) $display("FAIL reset_sum: got %0d expected 0", oSum); else n_passed++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", oBusy); else n_passed++;
    iRST = 1'b0;
    @(negedge iCLK);
    n_total++; if (oPixReady !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", oPixReady); else n_passed++;
  endtask

  task automatic test_basic();
    logic [7:0] px[25];
    for (int k = 0; k < 25; k++) px[k] = 8'(k + 1);
    got_q.delete(); got_cyc.delete();
    iReady = 1'b1;
    iWeights = fill_w(8'd1);
    drive_window(px, -1, '0);
    go_idle();
    n_total++; if (oValid !== 1'b0) $display("FAIL basic_valid_early: got %b expected 0", oValid); else n_passed++;
    @(negedge iCLK);
    n_total++; if (oValid !== 1'b1) $display("FAIL basic_valid_pulse: got %b expected 1", oValid); else n_passed++;
    n_total++; if (oSum !== 21'sd325) $display("FAIL basic_sum: got %0d expected 325", oSum); else n_passed++;
    @(negedge iCLK);
    n_total++; if (oValid !== 1'b0) $display("FAIL basic_valid_drop: got %b expected 0", oValid); else n_passed++;
    n_total++; if (got_q.size() != 1) $display("FAIL basic_count: got %0d expected 1", got_q.size()); else n_passed++;
  endtask

  task automatic test_extremes();
    logic [7:0] px[25];
    bit ok;
    for (int k = 0; k < 25; k++) px[k] = 8'd255;
    got_q.delete(); got_cyc.delete();
    iWeights = fill_w(8'h80);
    drive_window(px, -1, '0);
    iWeights = fill_w(8'd127);
    drive_window(px, -1, '0);
    go_idle();
    wait_results(2, ok);
    n_total++; if (!ok) $display("FAIL extremes_count: got %0d expected 2", got_q.size()); else n_passed++;
    if (ok) begin
      n_total++; if (got_q[0] != -816000) $display("FAIL extremes_min: got %0d expected -816000", got_q[0]); else n_passed++;
      n_total++; if (got_q[1] != 809625) $display("FAIL extremes_max: got %0d expected 809625", got_q[1]); else n_passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] px[25];
    bit ok;
    for (int k = 0; k < 25; k++) px[k] = 8'd2;
    got_q.delete(); got_cyc.delete();
    iWeights = fill_w(8'd3);
    drive_window(px, 10, fill_w(8'd5));
    drive_window(px, -1, '0);
    go_idle();
    wait_results(2, ok);
    n_total++; if (!ok) $display("FAIL b2b_count: got %0d expected 2", got_q.size()); else n_passed++;
    if (ok) begin
      n_total++; if (got_q[0] != 150) $display("FAIL b2b_snapshot_w1: got %0d expected 150", got_q[0]); else n_passed++;
      n_total++; if (got_q[1] != 250) $display("FAIL b2b_w2: got %0d expected 250", got_q[1]); else n_passed++;
      n_total++; if (got_cyc[1] - got_cyc[0] != 25) $display("FAIL b2b_spacing: got %0d expected 25", got_cyc[1] - got_cyc[0]); else n_passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pa[25];
    logic [7:0] pb[25];
    int c;
    for (int k = 0; k < 25; k++) begin
      pa[k] = 8'd2;
      pb[k] = 8'(k + 1);
    end
    got_q.delete(); got_cyc.delete();
    @(negedge iCLK);
    iReady = 1'b0;
    iWeights = fill_w(8'd3);
    drive_window(pa, -1, '0);
    iWeights = fill_w(8'd1);
    drive_window(pb, -1, '0);
    go_idle();
    #1;
    n_total++; if (oPixReady !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", oPixReady); else n_passed++;
    n_total++; if (oValid !== 1'b1) $display("FAIL bp_valid_hold: got %b expected 1", oValid); else n_passed++;
    repeat (3) @(negedge iCLK);
    n_total++; if (oSum !== 21'sd150) $display("FAIL bp_sum_hold: got %0d expected 150", oSum); else n_passed++;
    n_total++; if (oPixReady !== 1'b0) $display("FAIL bp_ready_still_low: got %b expected 0", oPixReady); else n_passed++;
    iReady = 1'b1;
    @(negedge iCLK);
    n_total++; if (oValid !== 1'b1) $display("FAIL bp_release_valid: got %b expected 1", oValid); else n_passed++;
    n_total++; if (oSum !== 21'sd325) $display("FAIL bp_release_sum: got %0d expected 325", oSum); else n_passed++;
    n_total++; if (oPixReady !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", oPixReady); else n_passed++;
    c = 0;
    while (got_q.size() < 2 && c < 20) begin
      @(posedge iCLK);
      c++;
    end
    n_total++;
    if (got_q.size() != 2 || got_q[0] != 150 || got_q[1] != 325)
      $display("FAIL bp_order: got %0d results expected 150 then 325", got_q.size());
    else n_passed++;
  endtask

  task automatic test_abort();
    logic [7:0] ones[25];
    bit ok;
    for (int k = 0; k < 25; k++) ones[k] = 8'd1;
    got_q.delete(); got_cyc.delete();
    iReady = 1'b1;
    iWeights = fill_w(8'd1);
    for (int k = 0; k < 12; k++) drive_pixel(8'd9);
    @(negedge iCLK);
    iClear = 1'b1; iPixValid = 1'b1; iPix = 8'd7;
    #1;
    n_total++; if (oPixReady !== 1'b0) $display("FAIL clear_ready: got %b expected 0", oPixReady); else n_passed++;
    @(negedge iCLK);
    iClear = 1'b0; iPixValid = 1'b0;
    n_total++; if (oBusy !== 1'b0) $display("FAIL clear_busy: got %b expected 0", oBusy); else n_passed++;
    drive_window(ones, -1, '0);
    go_idle();
    wait_results(1, ok);
    repeat (3) @(posedge iCLK);
    n_total++;
    if (!ok || got_q.size() != 1 || got_q[0] != 25)
      $display("FAIL clear_sum: got %0d results (first %0d) expected one of 25", got_q.size(), ok ? got_q[0] : 0);
    else n_passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] ones[25];
    bit ok;
    for (int k = 0; k < 25; k++) ones[k] = 8'd1;
    got_q.delete(); got_cyc.delete();
    for (int k = 0; k < 12; k++) drive_pixel(8'd9);
    @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    n_total++; if (oPixReady !== 1'b0) $display("FAIL rstmid_ready: got %b expected 0", oPixReady); else n_passed++;
    n_total++; if (oValid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", oValid); else n_passed++;
    n_total++; if (oSum !== 21'sd0) $display("FAIL rstmid_sum: got %0d expected 0", oSum); else n_passed++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", oBusy); else n_passed++;
    iRST = 1'b0; iPixValid = 1'b0;
    drive_window(ones, -1, '0);
    go_idle();
    wait_results(1, ok);
    n_total++;
    if (!ok || got_q[0] != 25) $display("FAIL rstmid_sum_after: got %0d expected 25", ok ? got_q[0] : 0);
    else n_passed++;
  endtask

  task automatic test_random();
    logic [7:0] px[25];
    logic [199:0] w;
    int exp_q[$];
    bit ok;
    got_q.delete(); got_cyc.delete();
    rand_ready = 1;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 25; k++) begin
        px[k] = 8'($urandom);
        w[8*k +: 8] = 8'($urandom);
      end
      exp_q.push_back(model(w, px));
      #1 iWeights = w;
      drive_window(px, 12, ~w);
      if ($urandom_range(0, 1) == 1) begin
        go_idle();
        repeat ($urandom_range(0, 4)) @(posedge iCLK);
      end
    end
    go_idle();
    rand_ready = 0;
    iReady = 1'b1;
    wait_results(8, ok);
    n_total++; if (!ok) $display("FAIL rand_count: got %0d expected 8", got_q.size()); else n_passed++;
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (got_q[i] != exp_q[i]) $display("FAIL rand_sum_%0d: got %0d expected %0d", i, got_q[i], exp_q[i]);
        else n_passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/conv5x5_mac.md
# conv5x5_mac

- Sequential 5×5 convolution multiply-accumulate stage, directly downstream of the 25-entry kernel weight register bank.
- Takes the 25 signed 8-bit kernel weights in parallel and a stream of unsigned 8-bit pixels, one window of 25 pixels in row-major order.
- Performs one multiply per accepted pixel and emits one exact 21-bit signed sum per window on a valid/ready output.
- Snapshots the kernel at the first tap of each window, so mid-window weight writes cannot corrupt a result.

## Interface
Parameters: none; all widths are fixed.

- iCLK  in  1  clock; all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- iWeights  in  200  kernel bank, tap k (0..24) at [8k+7:8k], signed two's complement; tap 0 = first kernel register
- iPixValid  in  1  pixel valid
- iPix  in  8  pixel, unsigned
- oPixReady  out  1  pixel accepted on an edge where iPixValid && oPixReady
- iClear  in  1  synchronous window abort
- oValid  out  1  result valid
- oSum  out  21  result, signed
- iReady  in  1  result consumed on an edge where oValid && iReady
- oBusy  out  1  window in progress (tap counter ≠ 0) or pipeline stage occupied

## Operation
- **Tap counter** tap[4:0]:
  - Increments on each accepted pixel.
  - Wraps 24→0.
- **Shadow kernel:**
  - On acceptance with tap==0, latch all 25 weights into shadow registers.
  - Tap 0 uses the live iWeights[7:0].
  - Taps 1..24 use the shadow registers.
  - Writes to the kernel bank during a window affect only the next window.
- **Stage 1 (product):** on acceptance, register:
  - pProd = signed(w[tap]) × {1'b0, iPix}, 17 bits signed
  - pValid = 1
  - pFirst = (tap==0)
  - pLast = (tap==24)
  - pValid clears on an edge without acceptance, unless the stage is stalled.
- **Stage 2 (accumulate):** when pValid and not stalled:
  - acc ← pFirst ? sext(pProd) : acc + sext(pProd), 21 bits.
  - If pLast, also oSum ← final value and oValid ← 1.
- **Width:** range is −816000..+809625 and fits 21-bit signed, so the sum is exact with no saturation or wrap.
- **Output register:** oValid clears on an edge with iReady and no new result. If a new result is written on the same edge that iReady drains the old one, oValid stays 1 with the new oSum.
- **Stall:** stall = pValid && pLast && oValid && !iReady.
  - While stalled: stage 1 holds, acc holds, and oPixReady = 0.
  - Otherwise oPixReady = 1.
- **iClear:**
  - Resets tap to 0 and drops pValid.
  - A partial accumulation is discarded.
  - oValid/oSum are untouched.
  - A pixel presented in the same cycle is not accepted (oPixReady = 0 while iClear).
- **Reset values:** on iRST, all outputs go to 0: oPixReady=0, oValid=0, oSum=0, oBusy=0. tap, acc, pValid and the shadow kernel also go to 0. oPixReady rises the first cycle after iRST deasserts.
- **Reset mid-window** discards the partial window. The next accepted pixel is tap 0.

## Timing
- **Latency:** the 25th pixel accepted at edge t gives oValid=1 after edge t+1. oSum is visible in the cycle following t+1.
- **Throughput:** one pixel per cycle sustained. Windows may run back-to-back with no bubble: tap 0 of window n+1 is accepted on the edge after tap 24 of window n.
- **Results:** at most one result is in flight. Results are never dropped or overwritten while oValid && !iReady.
- **Stall release:** if the stall clears on edge e (iReady=1), the held last product completes on edge e. oValid stays 1 with the new sum, and oPixReady returns to 1 in the cycle after edge e.
- **Simultaneous iClear and result:** a result already in stage 2 completes normally. iClear only affects tap and stage 1.

## Test plan
- **Basic sum:** all weights = 1, pixels 1..25 back-to-back, iReady=1 → single oValid pulse two cycles after the last pixel, oSum = 325.
- **Extremes:**
  - All weights = −128 (0x80), pixels 255 → oSum = −816000.
  - All weights = 127, pixels 255 → oSum = 809625.
- **Back-to-back windows with kernel snapshot:** two windows with no gap, pixels all 2, weights all 3 → two results of 150, 25 cycles apart. Change iWeights to all 5 at tap 10 of window 1 → window 1 result is still 150 and window 2 result is 250.
- **Backpressure:**
  - Hold iReady=0 after the first result and stream the second window. oPixReady falls once tap 24's product reaches stage 1; oSum keeps the first value.
  - Raise iReady → second result appears and oPixReady returns to 1.
- **Abort and reset:**
  - Assert iClear after 12 pixels, then send a full window of ones with weights 1 → oSum = 25.
  - Repeat with iRST mid-window → all outputs 0 during reset, then oSum = 25 for the next complete window.
